// File: rtl/im_loader.sv
// Loads an instruction memory from a byte stream. The stream is a 16-bit little-endian
// word count followed by that many little-endian 32-bit words. The core is stalled while a load runs.
module im_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          cpu_stall,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, BYTE, WRITE, DONE} state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t        state, nxt;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [AW-1:0] idx;
  logic [1:0]    bcnt;
  logic [23:0]   word;
  logic          take;
  logic [15:0]   n_rx;
  logic          last;
  logic          too_big;

  assign take    = rx_valid & rx_ready;
  assign n_rx    = {rx_data, len_lo};
  assign too_big = {1'b0, n_rx} > DEPTH_W;
  assign last    = (16'(idx) == len - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (start) nxt = LEN_LO;
      LEN_LO: if (take) nxt = LEN_HI;
      LEN_HI: if (take) begin
                if (n_rx == 16'd0) nxt = DONE;
                else if (too_big)  nxt = IDLE;
                else               nxt = BYTE;
              end
      BYTE:   if (take && bcnt == 2'd3) nxt = WRITE;
      WRITE:  nxt = last ? DONE : BYTE;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = (state == LEN_LO) || (state == LEN_HI) || (state == BYTE);
    we        = (state == WRITE);
    done      = (state == DONE);
    busy      = (state != IDLE);
    cpu_stall = (state != IDLE);
  end

  // waddr/wdata are loaded as the 4th byte lands, so they are valid throughout WRITE and hold afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err    <= 1'b0;
      len_lo <= '0;
      len    <= '0;
      idx    <= '0;
      bcnt   <= '0;
      word   <= '0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          err  <= 1'b0;
          idx  <= '0;
          bcnt <= '0;
        end
        LEN_LO: if (take) len_lo <= rx_data;
        LEN_HI: if (take) begin
          len <= n_rx;
          if (too_big) err <= 1'b1;
        end
        BYTE: if (take) begin
          bcnt <= bcnt + 2'd1;
          case (bcnt)
            2'd0: word[7:0]   <= rx_data;
            2'd1: word[15:8]  <= rx_data;
            2'd2: word[23:16] <= rx_data;
            default: begin
              wdata <= {rx_data, word};
              waddr <= idx;
            end
          endcase
        end
        // last word leaves idx in place so a full-depth load never wraps it
        WRITE: if (!last) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 256, giving the instruction-memory depth in 32-bit words.
REQ-002 The block SHALL provide parameter AW, default 8, giving the word-address width (2^AW = DEPTH).
REQ-003 The block SHALL run on one clock, and its reset SHALL be asynchronous and active-high.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-006 Port start: input, 1 bit, single-cycle request to begin a program load.
REQ-007 Port rx_valid: input, 1 bit, a byte is present on rx_data.
REQ-008 Port rx_data: input, 8 bits, stream byte.
REQ-009 Port rx_ready: output, 1 bit, the block accepts the byte this cycle.
REQ-010 Port we: output, 1 bit, instruction-memory write strobe.
REQ-011 Port waddr: output, AW bits, word index to write.
REQ-012 Port wdata: output, 32 bits, instruction word to write.
REQ-013 Port cpu_stall: output, 1 bit, holds the core (PC and fetch) while a load is in progress.
REQ-014 Port busy: output, 1 bit, a load is in progress.
REQ-015 Port done: output, 1 bit, one-cycle pulse when a load completes.
REQ-016 Port err: output, 1 bit, sticky flag for an invalid length.

Function
REQ-017 The stream format SHALL be: a 16-bit word count N, little-endian (LEN_LO, then LEN_HI), followed by N words of 4 bytes each, little-endian (byte0 goes to wdata[7:0]).
REQ-018 The FSM states SHALL be IDLE, LEN_LO, LEN_HI, BYTE, WRITE and DONE.
REQ-019 A byte SHALL be consumed only on a cycle where rx_valid and rx_ready are both high.
REQ-020 rx_ready SHALL be high only in LEN_LO, LEN_HI and BYTE.
REQ-021 rx_ready SHALL be low in IDLE, WRITE and DONE, and bytes offered in those states SHALL NOT be consumed.
REQ-022 IDLE -> LEN_LO SHALL occur when start=1.
REQ-023 Entering LEN_LO SHALL clear err, the word index and the byte counter.
REQ-024 start SHALL be ignored in every state except IDLE.
REQ-025 LEN_LO -> LEN_HI SHALL occur on a consumed byte.
REQ-026 On the consumed LEN_HI byte:
- if N=0, the FSM SHALL go to DONE;
- if N>DEPTH, the FSM SHALL set err=1 and go to IDLE with no write;
- otherwise the FSM SHALL go to BYTE.
REQ-027 In BYTE, the FSM SHALL assemble 4 consumed bytes, then go to WRITE on the cycle after the 4th byte is consumed.
REQ-028 In WRITE, we=1 for exactly one cycle, with waddr = current word index and wdata = the assembled word.
REQ-029 On leaving WRITE, the index SHALL increment; the FSM SHALL go to DONE if index = N-1, else back to BYTE.
REQ-030 In DONE, done=1 for one cycle, then the FSM SHALL go to IDLE.
REQ-031 we SHALL be high only in WRITE.
REQ-032 waddr and wdata SHALL hold their last values when we=0.
REQ-033 busy and cpu_stall SHALL be high in every state except IDLE, including the DONE cycle.
REQ-034 busy and cpu_stall SHALL be low in IDLE.
REQ-035 Gaps in rx_valid SHALL stall the FSM without data loss.
REQ-036 N=DEPTH (0x0100 at default) SHALL be legal, with the final write at waddr=DEPTH-1.
REQ-037 The word index SHALL NOT wrap.
REQ-038 Load latency SHALL be at most one cycle per consumed byte plus one WRITE cycle per word plus one DONE cycle; a back-to-back stream of N words SHALL complete in 2+5N+1 cycles after start.

Reset
REQ-039 While rst=1, the block SHALL force state=IDLE and all outputs to 0 (rx_ready, we, waddr, wdata, cpu_stall, busy, done, err), and clear the index and byte counter.
REQ-040 Reset mid-load SHALL abort immediately with no further write; memory contents already written are unaffected.
REQ-041 After reset, the next start SHALL restart the load at waddr=0.

Verification
REQ-042 Basic load: start; bytes 02 00 93 00 10 00 13 01 60 00 -> we at waddr 0 with 0x00100093, then we at waddr 1 with 0x00600113; one done pulse; cpu_stall low afterwards; err=0.
REQ-043 Empty program: start; bytes 00 00 -> done pulse, no we, err=0.
REQ-044 Oversize length: start; bytes 01 01 (N=257) -> err=1, no we, busy low.
REQ-045 Error clear: a later start SHALL clear err on entry to LEN_LO.
REQ-046 Backpressure: the same stream as the basic load, with random rx_valid gaps and rx_valid held high during WRITE -> identical writes, and no byte consumed during WRITE.
REQ-047 Reset mid-word: rst pulsed after the 2nd data byte of word 0 -> all outputs 0 immediately, no we; a new start with a full stream -> first write at waddr 0.
REQ-048 Start while busy: start re-asserted during BYTE -> ignored; write sequence and done timing unchanged.
